// File: rtl/axil_arb_master.sv
// Two-requester arbiter feeding a single-outstanding AXI4-Lite master sequencer.
// Optional build macro AXIL_ARB_FIXED_PRIO_EN: requester 0 always wins ties (default: round-robin).
module axil_arb_master #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32
) (
    input  logic                        ACLK,
    input  logic                        ARESET,
    input  logic [1:0]                  rq_valid,
    output logic [1:0]                  rq_ready,
    input  logic [1:0]                  rq_write,
    input  logic [2*ADDR_WIDTH-1:0]     rq_addr,
    input  logic [2*DATA_WIDTH-1:0]     rq_wdata,
    input  logic [2*DATA_WIDTH/8-1:0]   rq_wstrb,
    output logic [1:0]                  rsp_valid,
    output logic [DATA_WIDTH-1:0]       rsp_rdata,
    output logic [1:0]                  rsp_resp,
    output logic [ADDR_WIDTH-1:0]       m_awaddr,
    output logic                        m_awvalid,
    input  logic                        m_awready,
    output logic [DATA_WIDTH-1:0]       m_wdata,
    output logic [DATA_WIDTH/8-1:0]     m_wstrb,
    output logic                        m_wvalid,
    input  logic                        m_wready,
    input  logic [1:0]                  m_bresp,
    input  logic                        m_bvalid,
    output logic                        m_bready,
    output logic [ADDR_WIDTH-1:0]       m_araddr,
    output logic                        m_arvalid,
    input  logic                        m_arready,
    input  logic [DATA_WIDTH-1:0]       m_rdata,
    input  logic [1:0]                  m_rresp,
    input  logic                        m_rvalid,
    output logic                        m_rready
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    typedef enum logic [2:0] {
        IDLE,
        WR_ADDR,
        WR_RESP,
        RD_ADDR,
        RD_DATA
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic                    last_grant;
    logic                    grant;
    logic                    arb_sel;
    logic                    accept;
    logic                    cmd_write;
    logic [ADDR_WIDTH-1:0]   cmd_addr;
    logic [DATA_WIDTH-1:0]   cmd_wdata;
    logic [STRB_WIDTH-1:0]   cmd_wstrb;
    logic                    aw_done;
    logic                    w_done;
    logic                    aw_hs;
    logic                    w_hs;
    logic                    b_hs;
    logic                    ar_hs;
    logic                    r_hs;

    // Tie-break only matters when both requesters are valid.
    always_comb begin
        arb_sel = 1'b0;
        case (rq_valid)
            2'b01:   arb_sel = 1'b0;
            2'b10:   arb_sel = 1'b1;
`ifdef AXIL_ARB_FIXED_PRIO_EN
            2'b11:   arb_sel = 1'b0;
`else
            2'b11:   arb_sel = ~last_grant;
`endif
            default: arb_sel = 1'b0;
        endcase
    end

    assign accept = (state == IDLE) && (|rq_valid) && !ARESET;

    assign aw_hs = m_awvalid & m_awready;
    assign w_hs  = m_wvalid  & m_wready;
    assign b_hs  = m_bvalid  & m_bready;
    assign ar_hs = m_arvalid & m_arready;
    assign r_hs  = m_rvalid  & m_rready;

    assign m_awaddr = cmd_addr;
    assign m_araddr = cmd_addr;
    assign m_wdata  = cmd_wdata;
    assign m_wstrb  = cmd_wstrb;

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (arb_sel ? rq_write[1] : rq_write[0]) begin
                        state_nxt = WR_ADDR;
                    end else begin
                        state_nxt = RD_ADDR;
                    end
                end
            end
            WR_ADDR: begin
                if ((aw_done | aw_hs) && (w_done | w_hs)) begin
                    state_nxt = WR_RESP;
                end
            end
            WR_RESP: begin
                if (b_hs) begin
                    state_nxt = IDLE;
                end
            end
            RD_ADDR: begin
                if (ar_hs) begin
                    state_nxt = RD_DATA;
                end
            end
            RD_DATA: begin
                if (r_hs) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        rq_ready  = 2'b00;
        m_awvalid = 1'b0;
        m_wvalid  = 1'b0;
        m_bready  = 1'b0;
        m_arvalid = 1'b0;
        m_rready  = 1'b0;
        if (accept) begin
            rq_ready[arb_sel] = 1'b1;
        end
        case (state)
            WR_ADDR: begin
                m_awvalid = ~aw_done;
                m_wvalid  = ~w_done;
            end
            WR_RESP: m_bready  = 1'b1;
            RD_ADDR: m_arvalid = 1'b1;
            RD_DATA: m_rready  = 1'b1;
            default: ;
        endcase
    end

    // Command latch, channel-done flags and the one-cycle response pulse.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            last_grant <= 1'b1;
            grant      <= 1'b0;
            cmd_write  <= 1'b0;
            cmd_addr   <= '0;
            cmd_wdata  <= '0;
            cmd_wstrb  <= '0;
            aw_done    <= 1'b0;
            w_done     <= 1'b0;
            rsp_valid  <= 2'b00;
            rsp_rdata  <= '0;
            rsp_resp   <= 2'b00;
        end else begin
            rsp_valid <= 2'b00;
            if (accept) begin
                last_grant <= arb_sel;
                grant      <= arb_sel;
                cmd_write  <= arb_sel ? rq_write[1] : rq_write[0];
                cmd_addr   <= arb_sel ? rq_addr[ADDR_WIDTH +: ADDR_WIDTH]
                                      : rq_addr[0 +: ADDR_WIDTH];
                cmd_wdata  <= arb_sel ? rq_wdata[DATA_WIDTH +: DATA_WIDTH]
                                      : rq_wdata[0 +: DATA_WIDTH];
                cmd_wstrb  <= arb_sel ? rq_wstrb[STRB_WIDTH +: STRB_WIDTH]
                                      : rq_wstrb[0 +: STRB_WIDTH];
                aw_done    <= 1'b0;
                w_done     <= 1'b0;
            end
            if (state == WR_ADDR) begin
                if (aw_hs) aw_done <= 1'b1;
                if (w_hs)  w_done  <= 1'b1;
            end
            if (b_hs) begin
                rsp_valid <= grant ? 2'b10 : 2'b01;
                rsp_resp  <= m_bresp;
                rsp_rdata <= '0;
            end
            if (r_hs) begin
                rsp_valid <= grant ? 2'b10 : 2'b01;
                rsp_resp  <= m_rresp;
                rsp_rdata <= m_rdata;
            end
        end
    end

endmodule

// File: tb/tb_axil_arb_master.sv
// Scoreboard bench for axil_arb_master with a two-register AXI4-Lite slave model.
module tb_axil_arb_master;

    logic        ACLK = 1'b0;
    logic        ARESET = 1'b1;
    logic        v0 = 1'b0, v1 = 1'b0, wr0 = 1'b0, wr1 = 1'b0;
    logic [3:0]  a0 = '0, a1 = '0, s0 = '0, s1 = '0;
    logic [31:0] d0 = '0, d1 = '0;

    logic [1:0]  rq_valid, rq_ready, rq_write, rsp_valid, rsp_resp;
    logic [7:0]  rq_addr, rq_wstrb;
    logic [63:0] rq_wdata;
    logic [31:0] rsp_rdata;
    logic [3:0]  m_awaddr, m_araddr, m_wstrb;
    logic [31:0] m_wdata, m_rdata;
    logic        m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
    logic        m_arvalid, m_arready, m_rvalid, m_rready;
    logic [1:0]  m_bresp, m_rresp;

    assign rq_valid = {v1, v0};
    assign rq_write = {wr1, wr0};
    assign rq_addr  = {a1, a0};
    assign rq_wdata = {d1, d0};
    assign rq_wstrb = {s1, s0};

    axil_arb_master #(.ADDR_WIDTH(4), .DATA_WIDTH(32)) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .rq_valid(rq_valid), .rq_ready(rq_ready), .rq_write(rq_write),
        .rq_addr(rq_addr), .rq_wdata(rq_wdata), .rq_wstrb(rq_wstrb),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
        .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
        .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready)
    );

    always #5 ACLK = ~ACLK;

    // Slave model: CTRL @0x0, DATA @0x4, anything else answers SLVERR with zero data.
    logic        aw_got, w_got, s_bvalid, s_rvalid;
    logic [3:0]  s_awaddr, s_wstrb;
    logic [31:0] s_wdata, reg_ctrl, reg_data, s_rdata;
    logic [1:0]  s_bresp, s_rresp;
    int          aw_wait = 0;
    int          aw_stall = 0;
    int          bcount = 0;
    bit          b_hold = 1'b0;

    assign m_awready = !aw_got && !s_bvalid && (aw_wait >= aw_stall);
    assign m_wready  = !w_got && !s_bvalid;
    assign m_bvalid  = s_bvalid;
    assign m_bresp   = s_bresp;
    assign m_arready = !s_rvalid;
    assign m_rvalid  = s_rvalid;
    assign m_rdata   = s_rdata;
    assign m_rresp   = s_rresp;

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                          input logic [3:0] s);
        logic [31:0] r;
        r = o;
        for (int i = 0; i < 4; i++) if (s[i]) r[i*8 +: 8] = n[i*8 +: 8];
        return r;
    endfunction

    always @(posedge ACLK) begin
        if (ARESET) begin
            aw_got <= 1'b0; w_got <= 1'b0; s_bvalid <= 1'b0; s_rvalid <= 1'b0;
            reg_ctrl <= '0; reg_data <= '0; aw_wait <= 0;
            s_bresp <= '0; s_rresp <= '0; s_rdata <= '0;
            s_awaddr <= '0; s_wdata <= '0; s_wstrb <= '0;
        end else begin
            if (m_awvalid && !aw_got) begin
                if (m_awready) begin
                    aw_got <= 1'b1; s_awaddr <= m_awaddr; aw_wait <= 0;
                end else begin
                    aw_wait <= aw_wait + 1;
                end
            end
            if (m_wvalid && m_wready) begin
                w_got <= 1'b1; s_wdata <= m_wdata; s_wstrb <= m_wstrb;
            end
            if (aw_got && w_got && !s_bvalid && !b_hold) begin
                aw_got <= 1'b0; w_got <= 1'b0; s_bvalid <= 1'b1;
                if (s_awaddr == 4'h0) reg_ctrl <= merge(reg_ctrl, s_wdata, s_wstrb);
                if (s_awaddr == 4'h4) reg_data <= merge(reg_data, s_wdata, s_wstrb);
                s_bresp <= (s_awaddr == 4'h0 || s_awaddr == 4'h4) ? 2'b00 : 2'b10;
            end
            if (s_bvalid && m_bready) begin
                s_bvalid <= 1'b0; bcount <= bcount + 1;
            end
            if (m_arvalid && m_arready) begin
                s_rvalid <= 1'b1;
                s_rdata  <= (m_araddr == 4'h0) ? reg_ctrl : (m_araddr == 4'h4) ? reg_data : 32'h0;
                s_rresp  <= (m_araddr == 4'h0 || m_araddr == 4'h4) ? 2'b00 : 2'b10;
            end
            if (s_rvalid && m_rready) s_rvalid <= 1'b0;
        end
    end

    typedef struct packed {
        logic [1:0]  req;
        logic [1:0]  resp;
        logic [31:0] rdata;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    logic [1:0] prev_rsp = 2'b00;

    task automatic push(input int n, input logic [1:0] resp, input logic [31:0] rd);
        exp_t e;
        e.req   = (n == 0) ? 2'b01 : 2'b10;
        e.resp  = resp;
        e.rdata = rd;
        sb.push_back(e);
    endtask

    always @(negedge ACLK) begin
        if (rsp_valid != 2'b00) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL rsp_unexpected: got rsp_valid=%b resp=%b rdata=%h, required no response",
                         rsp_valid, rsp_resp, rsp_rdata);
            end else begin
                mon_e = sb.pop_front();
                if ({rsp_valid, rsp_resp, rsp_rdata} !== mon_e) begin
                    errors++;
                    $display("FAIL rsp_match: got valid=%b resp=%b rdata=%h, required valid=%b resp=%b rdata=%h",
                             rsp_valid, rsp_resp, rsp_rdata, mon_e.req, mon_e.resp, mon_e.rdata);
                end
            end
            checks++;
            if (prev_rsp != 2'b00) begin
                errors++;
                $display("FAIL rsp_pulse: got rsp_valid high two cycles (%b then %b), required one-cycle pulse",
                         prev_rsp, rsp_valid);
            end
        end
        if (rq_ready != 2'b00) begin
            checks++;
            if ($countones(rq_ready) != 1 || (rq_ready & ~rq_valid) != 2'b00) begin
                errors++;
                $display("FAIL rq_ready_onehot: got rq_ready=%b rq_valid=%b, required one-hot subset of rq_valid",
                         rq_ready, rq_valid);
            end
        end
        prev_rsp = rsp_valid;
    end

    task automatic issue(input int n, input logic w, input logic [3:0] a,
                         input logic [31:0] d, input logic [3:0] s);
        int c;
        bit done;
        @(negedge ACLK);
        if (n == 0) begin v0 = 1'b1; wr0 = w; a0 = a; d0 = d; s0 = s; end
        else        begin v1 = 1'b1; wr1 = w; a1 = a; d1 = d; s1 = s; end
        c = 0;
        done = 1'b0;
        while (!done) begin
            #1;
            if (rq_ready[n]) begin
                done = 1'b1;
            end else if (c >= 200) begin
                checks++; errors++;
                $display("FAIL accept_timeout: got no rq_ready[%0d] in %0d cycles, required accept", n, c);
                done = 1'b1;
            end else begin
                c++;
                @(negedge ACLK);
            end
        end
        @(posedge ACLK);
        #1;
        if (n == 0) v0 = 1'b0; else v1 = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        int c;
        c = 0;
        while (sb.size() != 0 && c < 300) begin
            @(negedge ACLK);
            c++;
        end
        if (sb.size() != 0) begin
            checks++; errors++;
            $display("FAIL %s_timeout: got %0d responses outstanding, required 0", tag, sb.size());
            sb.delete();
        end
        repeat (2) @(negedge ACLK);
    endtask

    task automatic do_reset();
        ARESET = 1'b1;
        v0 = 1'b1; v1 = 1'b1;
        repeat (2) @(negedge ACLK);
        checks++;
        if ({rq_ready, rsp_valid, rsp_resp, rsp_rdata, m_awvalid, m_wvalid, m_bready,
             m_arvalid, m_rready} !== '0) begin
            errors++;
            $display("FAIL reset_state: got rq_ready=%b rsp_valid=%b resp=%b rdata=%h aw/w/b/ar/r=%b%b%b%b%b, required all zero",
                     rq_ready, rsp_valid, rsp_resp, rsp_rdata, m_awvalid, m_wvalid, m_bready,
                     m_arvalid, m_rready);
        end
        v0 = 1'b0; v1 = 1'b0;
        ARESET = 1'b0;
        @(negedge ACLK);
    endtask

    logic [31:0] vals [4];

    initial begin
        int b0, hi, c;
        bit wlow;
        vals[0] = 32'h01234567; vals[1] = 32'h89ABCDEF;
        vals[2] = 32'h0F0F0F0F; vals[3] = 32'hF0F0F0F0;

        do_reset();

        // Single requester write then read-back of CTRL.
        push(0, 2'b00, 32'h0);
        issue(0, 1'b1, 4'h0, 32'hDEADBEEF, 4'hF);
        push(0, 2'b00, 32'hDEADBEEF);
        issue(0, 1'b0, 4'h0, 32'h0, 4'h0);
        wait_drain("t1");

        // Simultaneous requests right after reset: requester 0 first.
        do_reset();
        push(0, 2'b00, 32'h0);
        push(1, 2'b00, 32'h11111111);
        fork
            issue(0, 1'b1, 4'h4, 32'h11111111, 4'hF);
            issue(1, 1'b0, 4'h4, 32'h0, 4'h0);
        join
        wait_drain("t2");

        // Both requesters continuously busy: grants alternate 0,1,0,1...
        for (int i = 0; i < 4; i++) begin
            push(0, 2'b00, 32'h0);
            push(1, 2'b00, vals[i]);
        end
        fork
            for (int i = 0; i < 4; i++) issue(0, 1'b1, 4'h4, vals[i], 4'hF);
            for (int j = 0; j < 4; j++) issue(1, 1'b0, 4'h4, 32'h0, 4'h0);
        join
        wait_drain("t3");

        // Error responses, plus a partial-strobe write to DATA (was F0F0F0F0).
        push(1, 2'b10, 32'h0);
        issue(1, 1'b1, 4'h8, 32'h12345678, 4'hF);
        push(0, 2'b10, 32'h0);
        issue(0, 1'b0, 4'hC, 32'h0, 4'h0);
        push(0, 2'b00, 32'h0);
        issue(0, 1'b1, 4'h4, 32'h12345678, 4'h3);
        push(1, 2'b00, 32'hF0F05678);
        issue(1, 1'b0, 4'h4, 32'h0, 4'h0);
        wait_drain("t4");

        // AW stalled five cycles, W accepted immediately.
        aw_stall = 5;
        b0 = bcount;
        push(0, 2'b00, 32'h0);
        issue(0, 1'b1, 4'h4, 32'h55AA33CC, 4'hF);
        hi = 0; wlow = 1'b0; c = 0;
        @(negedge ACLK);
        while (m_awvalid && c < 20) begin
            checks++;
            if (m_awaddr !== 4'h4 || (wlow && m_wvalid)) begin
                errors++;
                $display("FAIL aw_stall_hold: got awaddr=%h wvalid=%b after W handshake, required awaddr=4 wvalid=0",
                         m_awaddr, m_wvalid);
            end
            if (!m_wvalid) wlow = 1'b1;
            hi++; c++;
            @(negedge ACLK);
        end
        checks++;
        if (hi != 6 || !wlow) begin
            errors++;
            $display("FAIL aw_stall_cycles: got awvalid for %0d cycles wvalid_dropped=%b, required 6 and 1", hi, wlow);
        end
        wait_drain("t5");
        checks++;
        if (bcount - b0 != 1) begin
            errors++;
            $display("FAIL single_b: got %0d B handshakes, required 1", bcount - b0);
        end
        aw_stall = 0;

        // Reset while waiting for B; no response, then a fresh read of CTRL.
        b_hold = 1'b1;
        issue(0, 1'b1, 4'h0, 32'hCAFEF00D, 4'hF);
        c = 0;
        while (!m_bready && c < 50) begin
            @(negedge ACLK);
            c++;
        end
        if (!m_bready) begin
            checks++; errors++;
            $display("FAIL wr_resp_timeout: got m_bready=0 after %0d cycles, required 1", c);
        end
        ARESET = 1'b1;
        v1 = 1'b1; wr1 = 1'b0; a1 = 4'h0; d1 = 32'h0; s1 = 4'h0;
        #1;
        checks++;
        if (rq_ready !== 2'b00) begin
            errors++;
            $display("FAIL rq_ready_in_reset: got %b, required 00", rq_ready);
        end
        @(negedge ACLK);
        checks++;
        if ({rq_ready, rsp_valid, m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready} !== '0) begin
            errors++;
            $display("FAIL midreset_idle: got rq_ready=%b rsp_valid=%b aw/w/b/ar/r=%b%b%b%b%b, required all zero",
                     rq_ready, rsp_valid, m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready);
        end
        ARESET = 1'b0;
        b_hold = 1'b0;
        v1 = 1'b0;
        push(1, 2'b00, 32'h0);
        issue(1, 1'b0, 4'h0, 32'h0, 4'h0);
        wait_drain("t6");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
